serial_compare: RTL
===================

# serial_compare

Parametrised successor to the 8-bit two-operand bit serialiser in the insertion-sort datapath. It loads two WIDTH-bit keys on a start request and shifts both out MSB-first on `x`/`y`. It also accumulates the magnitude comparison internally and reports less/equal/greater with a one-cycle done strobe. The sort controller uses it to compare and swap ASCII characters and wider keys.

## Interface
- `WIDTH`, default 8: key width in bits; legal range 2–32.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: synchronous active-high reset.
- `St`  in  1: start request; sampled only while `R`=1.
- `X`  in  WIDTH: key A; captured at the accepted start edge.
- `Y`  in  WIDTH: key B; captured at the accepted start edge.
- `R`  out  1: ready/idle.
- `D`  out  1: done strobe; high for exactly one cycle.
- `x`  out  1: current serial bit of A; equals XC[WIDTH-1].
- `y`  out  1: current serial bit of B; equals YC[WIDTH-1].
- `LT`  out  1: A<B (unsigned).
- `EQ`  out  1: A==B.
- `GT`  out  1: A>B.

## Operation
- Internal state:
  - XC, YC: WIDTH-bit shift registers.
  - cnt: $clog2(WIDTH+1)-bit down counter.
  - `dec`: decided flag.
  - FSM with states IDLE, SHIFT, DONE.
- Outputs per state:
  - IDLE: R=1, D=0.
  - SHIFT: R=0, D=0.
  - DONE: R=0, D=1.
- IDLE with St=1 at an edge:
  - XC<=X, YC<=Y, cnt<=WIDTH.
  - LT<=0, GT<=0, dec<=0.
  - Next state SHIFT.
- IDLE with St=0: all registers hold.
- Each SHIFT edge:
  - If !dec and x!=y: LT<=~x&y, GT<=x&~y, dec<=1.
  - XC<=XC<<1 and YC<=YC<<1 (zero fill).
  - cnt<=cnt-1.
  - If cnt==1, next state DONE.
- DONE edge: next state IDLE.
- Result flags:
  - EQ = ~LT & ~GT.
  - LT/GT/EQ are valid while D=1 and are held until the next accepted start.
- St while R=0 is ignored. No queueing; X and Y changes during SHIFT have no effect.
- Reset values:
  - State IDLE, R=1, D=0.
  - XC=YC=0, so x=y=0.
  - LT=GT=0, EQ=1, dec=0, cnt=0.
- Reset mid-operation: the next edge forces IDLE and the reset values. The partial result is discarded and no D pulse is produced.
- RST and St both high on the same edge: reset wins and the start is dropped.

## Timing
- Load edge E0. `x`/`y` present key bit WIDTH-1-k in the cycle after edge E0+k, for k=0..WIDTH-1.
- Full compare: D=1 in the cycle after edge E0+WIDTH. R=1 after edge E0+WIDTH+1. Start-to-start throughput is WIDTH+2 cycles.
- The flag LT/GT update is registered and is visible in the same cycle D rises.

## Configuration
- Macro `SERIAL_COMPARE_EARLY_EXIT_EN`.
- Defined:
  - The SHIFT edge that sets `dec` also transitions to DONE.
  - D rises k+1 cycles after E0, where k is the index of the first differing bit counted from the MSB.
  - Equal keys still take WIDTH cycles.
  - `x`/`y` stop shifting in DONE.
- Undefined:
  - Always WIDTH shift cycles.
  - The result is identical; only the latency differs.

## Test plan
- Reset, then idle 3 cycles -> R=1, D=0, EQ=1, LT=GT=0, x=y=0 throughout.
- WIDTH=8, X=0x61, Y=0x62, St pulse:
  - `x` sequence 0,1,1,0,0,0,0,1.
  - LT=1, EQ=0 when D=1.
  - D 8 cycles after load (7 with EARLY_EXIT).
- WIDTH=8, X=0x7A, Y=0x5A:
  - GT=1.
  - D after 8 cycles (3 with EARLY_EXIT).
- WIDTH=8, X=Y=0x41:
  - EQ=1.
  - D after 8 cycles in both builds.
  - R=1 one cycle after D.
- Start during SHIFT with new X/Y:
  - Ignored; the result matches the first operands.
  - RST asserted at shift cycle 4 -> IDLE next edge, no D pulse, flags at reset values.
- WIDTH=16, X=0x8000, Y=0x7FFF -> GT=1 with D after 16 cycles (1 with EARLY_EXIT); back-to-back starts are accepted exactly when R=1.

Source files
------------

// File: rtl/serial_compare.sv
// serial_compare: loads two keys, shifts them out MSB-first and reports LT/EQ/GT with a done strobe.
// Optional macro SERIAL_COMPARE_EARLY_EXIT_EN finishes on the first differing bit.
module serial_compare #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             St,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             R,
    output logic             D,
    output logic             x,
    output logic             y,
    output logic             LT,
    output logic             EQ,
    output logic             GT
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] xc, yc;
    logic [CW-1:0] cnt;
    logic dec, diff;
    assign x = xc[WIDTH-1];
    assign y = yc[WIDTH-1];
    assign EQ = ~LT & ~GT;
    assign diff = ~dec & (x ^ y);
    always_comb begin
        next = state;
        R = state == IDLE;
        D = state == DONE;
        case (state)
            IDLE:    next = St ? SHIFT : IDLE;
            SHIFT:   next = (cnt == CW'(1) || (EARLY && diff)) ? DONE : SHIFT;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            xc <= '0;
            yc <= '0;
            cnt <= '0;
            LT <= 1'b0;
            GT <= 1'b0;
            dec <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && St) begin
                xc <= X;
                yc <= Y;
                cnt <= CW'(WIDTH);
                LT <= 1'b0;
                GT <= 1'b0;
                dec <= 1'b0;
            end else if (state == SHIFT) begin
                // the first differing bit from the MSB decides the magnitude
                if (diff) begin
                    LT <= ~x & y;
                    GT <= x & ~y;
                    dec <= 1'b1;
                end
                xc <= xc << 1;
                yc <= yc << 1;
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule
